// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the two-port DMEM arbiter: FSM states, port
// indices and the width of the read-latency counter.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

  // Wide enough for RD_LAT values 0..7.
  localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. Purely combinational; the caller owns the
// last_grant register and updates it when a grant is actually taken.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      // On a tie the port that did not win last time goes next.
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported DMEM between the CPU load/store path (port 0) and
// the debug/DMA loader (port 1); one access at a time, IDLE -> ACCESS -> RESP.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 0
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              cpu_stall,
  output logic              busy,
  output logic              CS,
  output logic              DM_R,
  output logic              DM_W,
  output logic [ADDR_W-1:0] DMEMaddr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] DMEMdata
);

  // One extra bit so DEPTH*4 is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 4);

  arb_state_e           state, state_nxt;
  logic                 last_grant;
  logic                 grant_valid, grant_idx;
  logic                 sel_we, sel_err;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 lat_port, lat_we, lat_err;
  logic [ADDR_W-1:0]    lat_addr;
  logic [DATA_W-1:0]    lat_wdata;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 access_done;
  logic [DATA_W-1:0]    rdata0, rdata1;

  rr_arbiter2 u_rr (
    .req         ({m1_req, m0_req}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    sel_we    = (grant_idx == P_DBG) ? m1_we    : m0_we;
    sel_addr  = (grant_idx == P_DBG) ? m1_addr  : m0_addr;
    sel_wdata = (grant_idx == P_DBG) ? m1_wdata : m0_wdata;
    sel_err   = ({1'b0, sel_addr} >= ADDR_LIMIT) || (sel_addr[1:0] != 2'b00);
  end

  // Writes take a single ACCESS cycle; reads hold DM_R for RD_LAT+1 cycles.
  assign access_done = lat_we || (lat_cnt == LAT_CNT_W'(RD_LAT));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (grant_valid) state_nxt = sel_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (access_done) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Grant-time capture of the winning request; later input changes are ignored.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      last_grant <= P_DBG;
      lat_port   <= P_CPU;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_cnt    <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else if (state == ST_IDLE && grant_valid) begin
      last_grant <= grant_idx;
      lat_port   <= grant_idx;
      lat_we     <= sel_we;
      lat_err    <= sel_err;
      lat_addr   <= sel_addr;
      lat_wdata  <= sel_wdata;
      lat_cnt    <= '0;
      if (sel_err && !sel_we) begin
        if (grant_idx == P_DBG) rdata1 <= '0;
        else                    rdata0 <= '0;
      end
    end else if (state == ST_ACCESS && !lat_we) begin
      if (access_done) begin
        if (lat_port == P_DBG) rdata1 <= DMEMdata;
        else                   rdata0 <= DMEMdata;
      end else begin
        lat_cnt <= lat_cnt + LAT_CNT_W'(1);
      end
    end
  end

  // DMEM controls are decoded from state so reset drops them immediately.
  always_comb begin
    CS       = 1'b0;
    DM_R     = 1'b0;
    DM_W     = 1'b0;
    DMEMaddr = '0;
    dm_wdata = '0;
    m0_ack   = (state == ST_RESP) && (lat_port == P_CPU);
    m1_ack   = (state == ST_RESP) && (lat_port == P_DBG);
    m0_err   = m0_ack && lat_err;
    m1_err   = m1_ack && lat_err;
    if (state == ST_ACCESS) begin
      CS       = 1'b1;
      DMEMaddr = lat_addr;
      DM_W     = lat_we;
      DM_R     = !lat_we;
      dm_wdata = lat_we ? lat_wdata : '0;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign cpu_stall = m0_req & ~m0_ack;
  assign m0_rdata  = rdata0;
  assign m1_rdata  = rdata1;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: one instance with RD_LAT=0 and
// one with RD_LAT=3, each with a DMEM model, checked against a transaction model.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        m0_req    [2];
  logic        m0_we     [2];
  logic [31:0] m0_addr   [2];
  logic [31:0] m0_wdata  [2];
  logic [31:0] m0_rdata  [2];
  logic        m0_ack    [2];
  logic        m0_err    [2];
  logic        m1_req    [2];
  logic        m1_we     [2];
  logic [31:0] m1_addr   [2];
  logic [31:0] m1_wdata  [2];
  logic [31:0] m1_rdata  [2];
  logic        m1_ack    [2];
  logic        m1_err    [2];
  logic        cpu_stall [2];
  logic        busy      [2];
  logic        cs        [2];
  logic        dm_r      [2];
  logic        dm_w      [2];
  logic [31:0] dmem_addr [2];
  logic [31:0] dm_wdata  [2];
  logic [31:0] dmem_data [2];

  int total = 0;
  int bad   = 0;
  int last_dmr;
  int last_cs;

  logic [31:0] ref_mem   [2][1024];
  logic [31:0] ref_rdata [2][2];
  logic        ref_last  [2];

  function automatic logic [31:0] init_val(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : 3;
    logic [31:0] mem [0:1023];

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .RD_LAT(LAT)) u_dut (
      .clk_in(clk), .reset(rst_n[g]),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_rdata(m0_rdata[g]), .m0_ack(m0_ack[g]), .m0_err(m0_err[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_rdata(m1_rdata[g]), .m1_ack(m1_ack[g]), .m1_err(m1_err[g]),
      .cpu_stall(cpu_stall[g]), .busy(busy[g]), .CS(cs[g]), .DM_R(dm_r[g]), .DM_W(dm_w[g]),
      .DMEMaddr(dmem_addr[g]), .dm_wdata(dm_wdata[g]), .DMEMdata(dmem_data[g])
    );

    // Asynchronous-read DMEM; write on the rising edge while DM_W is high.
    assign dmem_data[g] = mem[dmem_addr[g][11:2]];

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
      forever begin
        @(posedge clk);
        if (dm_w[g]) mem[dmem_addr[g][11:2]] = dm_wdata[g];
      end
    end
  end

  function automatic logic is_bad(logic [31:0] a);
    return (a >= 32'd4096) || ((a % 4) != 0);
  endfunction

  function automatic int lat_of(int k, logic we, logic [31:0] a);
    if (is_bad(a)) return 1;
    if (we) return 2;
    return (k == 0) ? 2 : 5;
  endfunction

  function automatic logic get_ack(int k, int p);
    return (p == 0) ? m0_ack[k] : m1_ack[k];
  endfunction

  function automatic logic get_err(int k, int p);
    return (p == 0) ? m0_err[k] : m1_err[k];
  endfunction

  function automatic logic [31:0] get_rdata(int k, int p);
    return (p == 0) ? m0_rdata[k] : m1_rdata[k];
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = int'($urandom_range(0, 7));
    if (r == 0) return 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
    if (r == 1) return 32'd4096 + ($urandom & 32'h0000_FFFC);
    return 32'(4 * $urandom_range(0, 1023));
  endfunction

  task automatic drive_port(input int k, input int p, input logic req, input logic we,
                            input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      m0_req[k] = req; m0_we[k] = we; m0_addr[k] = a; m0_wdata[k] = wd;
    end else begin
      m1_req[k] = req; m1_we[k] = we; m1_addr[k] = a; m1_wdata[k] = wd;
    end
  endtask

  task automatic model_complete(input int k, input int p, input logic we,
                                input logic [31:0] a, input logic [31:0] wd);
    if (is_bad(a)) begin
      if (!we) ref_rdata[k][p] = 32'h0;
    end else if (we) begin
      ref_mem[k][int'(a) / 4] = wd;
    end else begin
      ref_rdata[k][p] = ref_mem[k][int'(a) / 4];
    end
  endtask

  // Issues one request in the current IDLE cycle, holds it until ack and
  // returns in the following IDLE cycle.
  task automatic single_txn(input int k, input int p, input logic we,
                            input logic [31:0] a, input logic [31:0] wd, input string name);
    int   exp_lat;
    logic exp_ack;
    exp_lat  = lat_of(k, we, a);
    last_dmr = 0;
    last_cs  = 0;
    drive_port(k, p, 1'b1, we, a, wd);
    ref_last[k] = (p == 1);
    for (int n = 1; n <= exp_lat; n++) begin
      @(negedge clk);
      exp_ack = (n == exp_lat);
      if (dm_r[k]) last_dmr++;
      if (cs[k]) last_cs++;
      if (exp_ack) model_complete(k, p, we, a, wd);
      total++;
      if (get_ack(k, p) !== exp_ack) begin
        bad++; $display("[TB] FAIL %s ack cycle %0d: got %b want %b", name, n, get_ack(k, p), exp_ack);
      end
      total++;
      if (get_ack(k, 1 - p) !== 1'b0) begin
        bad++; $display("[TB] FAIL %s other_ack cycle %0d: got %b want 0", name, n, get_ack(k, 1 - p));
      end
      total++;
      if (cpu_stall[k] !== ((p == 0) && !exp_ack)) begin
        bad++; $display("[TB] FAIL %s cpu_stall cycle %0d: got %b want %b", name, n, cpu_stall[k], (p == 0) && !exp_ack);
      end
      if (exp_ack) begin
        total++;
        if (get_err(k, p) !== is_bad(a)) begin
          bad++; $display("[TB] FAIL %s err: got %b want %b", name, get_err(k, p), is_bad(a));
        end
        total++;
        if (get_rdata(k, p) !== ref_rdata[k][p]) begin
          bad++; $display("[TB] FAIL %s rdata: got %h want %h", name, get_rdata(k, p), ref_rdata[k][p]);
        end
        drive_port(k, p, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    @(negedge clk);
    total++;
    if ({get_ack(k, p), busy[k]} !== 2'b00) begin
      bad++; $display("[TB] FAIL %s idle_after: got ack/busy %b%b want 00", name, get_ack(k, p), busy[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      drive_port(k, 0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_port(k, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({m0_ack[k], m1_ack[k], m0_err[k], m1_err[k], busy[k], cpu_stall[k]} !== 6'b0) begin
        bad++; $display("[TB] FAIL reset_flags[%0d]: got %b want 000000", k,
                        {m0_ack[k], m1_ack[k], m0_err[k], m1_err[k], busy[k], cpu_stall[k]});
      end
      total++;
      if ({cs[k], dm_r[k], dm_w[k]} !== 3'b0) begin
        bad++; $display("[TB] FAIL reset_dmem_ctl[%0d]: got %b want 000", k, {cs[k], dm_r[k], dm_w[k]});
      end
      total++;
      if ({dmem_addr[k], dm_wdata[k]} !== 64'h0) begin
        bad++; $display("[TB] FAIL reset_dmem_bus[%0d]: got %h want 0", k, {dmem_addr[k], dm_wdata[k]});
      end
      total++;
      if ({m0_rdata[k], m1_rdata[k]} !== 64'h0) begin
        bad++; $display("[TB] FAIL reset_rdata[%0d]: got %h want 0", k, {m0_rdata[k], m1_rdata[k]});
      end
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    single_txn(0, 0, 1'b1, 32'h10, 32'hDEAD_BEEF, "wr_0x10");
    single_txn(0, 0, 1'b0, 32'h10, 32'h0, "rd_0x10");
    total++;
    if (m0_rdata[0] !== 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL wr_rd_value: got %h want deadbeef", m0_rdata[0]);
    end
  endtask

  task automatic test_latency();
    single_txn(1, 1, 1'b0, 32'h88, 32'h0, "lat3_rd");
    total++;
    if (last_dmr !== 4) begin
      bad++; $display("[TB] FAIL lat3_dm_r_cycles: got %0d want 4", last_dmr);
    end
    single_txn(1, 1, 1'b1, 32'h8C, $urandom, "lat3_wr");
    total++;
    if (last_cs !== 1) begin
      bad++; $display("[TB] FAIL lat3_wr_cs_cycles: got %0d want 1", last_cs);
    end
  endtask

  task automatic test_errors();
    single_txn(1, 1, 1'b0, 32'h1002, 32'h0, "err_unaligned");
    total++;
    if (last_cs !== 0) begin
      bad++; $display("[TB] FAIL err_unaligned_cs: got %0d want 0", last_cs);
    end
    single_txn(1, 1, 1'b0, 32'h20, 32'h0, "pre_err_rd");
    single_txn(1, 1, 1'b0, 32'h1000, 32'h0, "err_range");
    total++;
    if (last_cs !== 0 || m1_rdata[1] !== 32'h0) begin
      bad++; $display("[TB] FAIL err_range_cs_rdata: got cs=%0d rdata=%h want cs=0 rdata=0", last_cs, m1_rdata[1]);
    end
  endtask

  task automatic test_reset_midread();
    single_txn(1, 0, 1'b0, 32'h24, 32'h0, "pre_rst_rd0");
    single_txn(1, 1, 1'b0, 32'h28, 32'h0, "pre_rst_rd1");
    drive_port(1, 1, 1'b1, 1'b0, 32'h40, 32'h0);
    repeat (2) @(negedge clk);
    total++;
    if (dm_r[1] !== 1'b1) begin
      bad++; $display("[TB] FAIL midread_dm_r: got %b want 1", dm_r[1]);
    end
    rst_n[1] = 1'b0;
    drive_port(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    total++;
    if ({cs[1], dm_r[1], dm_w[1], busy[1], m0_ack[1], m1_ack[1], cpu_stall[1]} !== 7'b0) begin
      bad++; $display("[TB] FAIL midreset_ctl: got %b want 0",
                      {cs[1], dm_r[1], dm_w[1], busy[1], m0_ack[1], m1_ack[1], cpu_stall[1]});
    end
    total++;
    if ({m0_rdata[1], m1_rdata[1], dmem_addr[1]} !== 96'h0) begin
      bad++; $display("[TB] FAIL midreset_data: got %h want 0", {m0_rdata[1], m1_rdata[1], dmem_addr[1]});
    end
    ref_last[1]     = 1'b1;
    ref_rdata[1][0] = 32'h0;
    ref_rdata[1][1] = 32'h0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({m0_ack[1], m1_ack[1], busy[1]} !== 3'b0) begin
        bad++; $display("[TB] FAIL post_reset_quiet: got %b want 000", {m0_ack[1], m1_ack[1], busy[1]});
      end
    end
  endtask

  // Both ports request continuously; each ack is followed by a fresh request.
  task automatic test_contention(input int k, input int ntxn);
    logic        cw [2];
    logic [31:0] ca [2];
    logic [31:0] cd [2];
    int          exp_p, exp_lat;
    logic        exp_ack;
    for (int p = 0; p < 2; p++) begin
      cw[p] = 1'($urandom_range(0, 1));
      ca[p] = 32'(4 * $urandom_range(0, 1023));
      cd[p] = $urandom;
      drive_port(k, p, 1'b1, cw[p], ca[p], cd[p]);
    end
    for (int t = 0; t < ntxn; t++) begin
      exp_p = ref_last[k] ? 0 : 1;
      ref_last[k] = (exp_p == 1);
      exp_lat = lat_of(k, cw[exp_p], ca[exp_p]);
      for (int n = 1; n <= exp_lat; n++) begin
        @(negedge clk);
        exp_ack = (n == exp_lat);
        if (exp_ack) model_complete(k, exp_p, cw[exp_p], ca[exp_p], cd[exp_p]);
        total++;
        if (get_ack(k, exp_p) !== exp_ack || get_ack(k, 1 - exp_p) !== 1'b0) begin
          bad++; $display("[TB] FAIL contend txn %0d port %0d cycle %0d: got acks %b%b want port ack %b",
                          t, exp_p, n, m1_ack[k], m0_ack[k], exp_ack);
        end
        total++;
        if (cpu_stall[k] !== !(exp_ack && exp_p == 0)) begin
          bad++; $display("[TB] FAIL contend_stall txn %0d: got %b want %b", t, cpu_stall[k], !(exp_ack && exp_p == 0));
        end
        if (exp_ack) begin
          total++;
          if (get_rdata(k, exp_p) !== ref_rdata[k][exp_p]) begin
            bad++; $display("[TB] FAIL contend_rdata txn %0d: got %h want %h", t, get_rdata(k, exp_p), ref_rdata[k][exp_p]);
          end
          cw[exp_p] = 1'($urandom_range(0, 1));
          ca[exp_p] = 32'(4 * $urandom_range(0, 1023));
          cd[exp_p] = $urandom;
          drive_port(k, exp_p, 1'b1, cw[exp_p], ca[exp_p], cd[exp_p]);
        end
      end
      @(negedge clk);
      total++;
      if ({m0_ack[k], m1_ack[k]} !== 2'b00) begin
        bad++; $display("[TB] FAIL contend_gap txn %0d: got acks %b want 00", t, {m1_ack[k], m0_ack[k]});
      end
    end
    drive_port(k, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(k, 1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_abandon();
    logic [31:0] d;
    d = $urandom;
    drive_port(0, 0, 1'b1, 1'b1, 32'h2C, d);
    ref_last[0] = 1'b0;
    @(negedge clk);
    total++;
    if ({dm_w[0], dmem_addr[0], dm_wdata[0]} !== {1'b1, 32'h2C, d}) begin
      bad++; $display("[TB] FAIL abandon_access: got w=%b a=%h d=%h want w=1 a=2c d=%h", dm_w[0], dmem_addr[0], dm_wdata[0], d);
    end
    drive_port(0, 0, 1'b0, 1'b0, 32'hFFFF_FFF0, ~d);
    drive_port(0, 1, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
    @(negedge clk);
    model_complete(0, 0, 1'b1, 32'h2C, d);
    total++;
    if ({m0_ack[0], m1_ack[0], cpu_stall[0]} !== 3'b100) begin
      bad++; $display("[TB] FAIL abandon_ack: got m0/m1/stall %b want 100", {m0_ack[0], m1_ack[0], cpu_stall[0]});
    end
    drive_port(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if ({m0_ack[0], m1_ack[0], busy[0]} !== 3'b000) begin
      bad++; $display("[TB] FAIL abandon_after: got m0/m1/busy %b want 000", {m0_ack[0], m1_ack[0], busy[0]});
    end
    single_txn(0, 1, 1'b0, 32'h30, 32'h0, "abandon_no_m1_write");
    single_txn(0, 0, 1'b0, 32'h2C, 32'h0, "abandon_readback");
  endtask

  // Random traffic on both ports, held until ack, inputs scrambled after grant.
  task automatic test_random(input int k, input int ncyc);
    logic        ron [2];
    logic        rwe [2];
    logic [31:0] radr [2];
    logic [31:0] rwd [2];
    logic        exp_ack [2];
    logic        act, gwe, exp_cs;
    logic [31:0] gadr, gwd;
    int          gp, g_cyc, ack_at, free_at, cyc;
    for (int p = 0; p < 2; p++) begin
      ron[p] = 1'b0; rwe[p] = 1'b0; radr[p] = 32'h0; rwd[p] = 32'h0;
    end
    act = 1'b0; gwe = 1'b0; gadr = 32'h0; gwd = 32'h0;
    gp = 0; g_cyc = 0; ack_at = 0; free_at = 0;
    for (cyc = 0; cyc < ncyc + 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int p = 0; p < 2; p++) exp_ack[p] = act && (ack_at == cyc) && (gp == p);
      exp_cs = act && !is_bad(gadr) && (cyc > g_cyc) && (cyc < ack_at);
      if (act && ack_at == cyc) model_complete(k, gp, gwe, gadr, gwd);
      for (int p = 0; p < 2; p++) begin
        total++;
        if (get_ack(k, p) !== exp_ack[p] || get_err(k, p) !== (exp_ack[p] && is_bad(gadr))) begin
          bad++; $display("[TB] FAIL rand[%0d] ack/err port %0d cycle %0d: got %b%b want %b%b", k, p, cyc,
                          get_ack(k, p), get_err(k, p), exp_ack[p], exp_ack[p] && is_bad(gadr));
        end
        total++;
        if (get_rdata(k, p) !== ref_rdata[k][p]) begin
          bad++; $display("[TB] FAIL rand[%0d] rdata port %0d cycle %0d: got %h want %h", k, p, cyc,
                          get_rdata(k, p), ref_rdata[k][p]);
        end
      end
      total++;
      if (cpu_stall[k] !== (ron[0] && !exp_ack[0])) begin
        bad++; $display("[TB] FAIL rand[%0d] stall cycle %0d: got %b want %b", k, cyc, cpu_stall[k], ron[0] && !exp_ack[0]);
      end
      total++;
      if (cs[k] !== exp_cs || (dm_r[k] && dm_w[k]) !== 1'b0) begin
        bad++; $display("[TB] FAIL rand[%0d] dmem_ctl cycle %0d: got cs=%b r=%b w=%b want cs=%b", k, cyc,
                        cs[k], dm_r[k], dm_w[k], exp_cs);
      end
      if (act && ack_at == cyc) begin
        ron[gp] = 1'b0;
        drive_port(k, gp, 1'b0, rwe[gp], radr[gp], rwd[gp]);
        act = 1'b0;
        free_at = cyc + 1;
      end else if (act && cyc == g_cyc + 1) begin
        rwe[gp] = ~rwe[gp]; radr[gp] = rand_addr(); rwd[gp] = $urandom;
        drive_port(k, gp, 1'b1, rwe[gp], radr[gp], rwd[gp]);
      end
      for (int p = 0; p < 2; p++) begin
        if (!ron[p] && cyc < ncyc && $urandom_range(0, 2) == 0) begin
          ron[p] = 1'b1; rwe[p] = 1'($urandom_range(0, 1)); radr[p] = rand_addr(); rwd[p] = $urandom;
          drive_port(k, p, 1'b1, rwe[p], radr[p], rwd[p]);
        end
      end
      if (!act && cyc >= free_at && (ron[0] || ron[1])) begin
        if (ron[0] && ron[1]) gp = ref_last[k] ? 0 : 1;
        else                  gp = ron[0] ? 0 : 1;
        ref_last[k] = (gp == 1);
        gwe = rwe[gp]; gadr = radr[gp]; gwd = rwd[gp];
        g_cyc = cyc; ack_at = cyc + lat_of(k, gwe, gadr); act = 1'b1;
      end
      if (cyc >= ncyc && !act && !ron[0] && !ron[1]) break;
    end
    total++;
    if (act || ron[0] || ron[1]) begin
      bad++; $display("[TB] FAIL rand[%0d] drain: got pending=%b%b%b want 000", k, act, ron[1], ron[0]);
    end
    drive_port(k, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(k, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_val(i);
      ref_rdata[k][0] = 32'h0;
      ref_rdata[k][1] = 32'h0;
      ref_last[k]     = 1'b1;
    end
    test_reset();
    test_write_read();
    test_latency();
    test_errors();
    test_reset_midread();
    test_contention(1, 8);
    test_contention(0, 8);
    test_abandon();
    test_random(0, 400);
    test_random(1, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
